counter_scheduler: RTL and testbench
====================================

COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 200000000, clock cycles per second, used by the run watchdog.
REQ-002 SHALL have parameter SUM_WIDTH, default 40, width of each per-channel accumulated sum.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port res  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port go  in  1  single-cycle pulse that starts a sequence; sampled in IDLE, DONE and ERROR only.
REQ-006 SHALL have port abort  in  1  level; ends an active sequence.
REQ-007 SHALL have port cfg_runs  in  8  number of runs per sequence; 0 treated as 1.
REQ-008 SHALL have port cfg_time  in  8  per-run count time in seconds, copy of the counter's time register, used only for the watchdog.
REQ-009 SHALL have port cnt_start  out  1  start strobe to the counter.
REQ-010 SHALL have port cnt_stop  in  1  stop level from the counter, held high for a finite window after each run.
REQ-011 SHALL have port cnt_data  in  4x32  per-channel counter results, valid while cnt_stop is high.
REQ-012 SHALL have port sum_data  out  4xSUM_WIDTH  per-channel accumulated totals.
REQ-013 SHALL have port run_idx  out  8  number of completed runs in the current sequence.
REQ-014 SHALL have ports busy, done, timeout  out  1 each  status: sequence active, sequence finished, watchdog fired.

Function
REQ-015 SHALL implement states IDLE, ARM, WAIT_STOP, CAPTURE, GAP, DONE, ERROR.
REQ-016 IDLE/DONE/ERROR + go SHALL clear sum_data, run_idx, done and timeout, latch cfg_runs and cfg_time, and enter ARM next cycle.
REQ-017 ARM SHALL drive cnt_start high for exactly one cycle, clear the watchdog, and enter WAIT_STOP.
REQ-018 WAIT_STOP SHALL detect the cnt_stop rising edge using a registered copy of cnt_stop, then enter CAPTURE; a cnt_stop level already high on entry SHALL NOT count as an edge.
REQ-019 CAPTURE SHALL, in one cycle, add each cnt_data[i] (zero-extended) to sum_data[i], increment run_idx, then enter GAP.
REQ-020 GAP SHALL wait until cnt_stop is low, then enter DONE if run_idx equals the latched run count, else ARM.
REQ-021 DONE SHALL hold done=1 and all outputs stable until go or res.
REQ-022 The watchdog SHALL count whole seconds, using a CLK_FREQ-cycle prescaler, in WAIT_STOP and GAP. When seconds exceeds latched cfg_time+2, it SHALL set timeout=1 and enter ERROR.
REQ-023 abort SHALL force the next state to IDLE from any active state and keep sum_data and run_idx; abort has priority over every transition, including go in the same cycle.
REQ-024 busy SHALL be 1 in ARM, WAIT_STOP, CAPTURE and GAP, else 0.
REQ-025 go SHALL be ignored in active states.
REQ-026 Sums SHALL wrap modulo 2^SUM_WIDTH unless REQ-030 applies.

Reset
REQ-027 res SHALL take priority over abort and go and return to IDLE.
REQ-028 While res is high, all outputs SHALL be zero: cnt_start, sum_data, run_idx, busy, done, timeout.
REQ-029 res mid-sequence SHALL discard partial sums; the counter is not re-strobed.

Configuration
REQ-030 With COUNTER_SCHED_SAT_EN defined, each sum SHALL saturate at 2^SUM_WIDTH-1, and an extra output sat_flag[3:0] SHALL latch per-channel saturation, cleared by go or res. Without the macro, sums SHALL wrap and sat_flag SHALL be absent.

Structure
REQ-031 Package counter_sched_pkg SHALL hold the state enum, NUM_CH=4 and CNT_WIDTH=32.
REQ-032 The watchdog (prescaler plus seconds counter, clear/enable in, seconds out) SHALL be sub-module counter_sched_wdog.

Verification (CLK_FREQ=1000, counter model asserts stop 1.2 s after start, for 10 cycles)
REQ-033 cfg_runs=3, cnt_data={5,6,7,8} each run, go -> three 1-cycle cnt_start pulses; sum_data={15,18,21,24}; run_idx=3; done=1; busy=0.
REQ-034 cfg_runs=0, go -> exactly one cnt_start pulse; run_idx=1; done=1.
REQ-035 cfg_time=1, model never raises stop -> timeout=1, state ERROR, no further cnt_start; a following go restarts with sums cleared.
REQ-036 abort during run 2 of 4 -> IDLE next cycle; run_idx=1; busy=0; done=0; go in the same cycle as abort ignored.
REQ-037 SUM_WIDTH=33, two runs of cnt_data[0]=0xFFFFFFFF -> 0x1FFFFFFFE; with COUNTER_SCHED_SAT_EN and SUM_WIDTH=32 -> 0xFFFFFFFF and sat_flag[0]=1.
REQ-038 res pulsed in WAIT_STOP -> next cycle all outputs 0 and state IDLE; a late cnt_stop edge causes no capture.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// -----------------------------------------------------------------------------
// counter_sched_pkg
// Shared definitions for the counter scheduler: channel count, counter result
// width, watchdog seconds width, the sequencer state encoding and a helper
// that tells whether a state belongs to an active sequence.
// Optional feature macro used elsewhere in this slice: COUNTER_SCHED_SAT_EN.
// -----------------------------------------------------------------------------
package counter_sched_pkg;

    localparam int NUM_CH    = 4;
    localparam int CNT_WIDTH = 32;

    // Wide enough for cfg_time (8 bits) + 2 + 1 without wrapping.
    localparam int SEC_WIDTH = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        WAIT_STOP = 3'd2,
        CAPTURE   = 3'd3,
        GAP       = 3'd4,
        DONE      = 3'd5,
        ERROR     = 3'd6
    } state_t;

    // Active-sequence states: busy is high here and abort is honoured here.
    function automatic logic state_is_busy(input state_t s);
        return (s == ARM) || (s == WAIT_STOP) || (s == CAPTURE) || (s == GAP);
    endfunction

endpackage

// File: rtl/counter_scheduler_if.sv
// -----------------------------------------------------------------------------
// counter_scheduler_if
// Link between the scheduler (master) and the external counter (slave).
//   cnt_start : scheduler -> counter, one-cycle start strobe
//   cnt_stop  : counter -> scheduler, level, high for a finite window per run
//   cnt_data  : counter -> scheduler, per-channel results
// Handshake: cnt_start is a strobe with no ready/acknowledge; the counter
// accepts it unconditionally. cnt_stop acts as "valid" for cnt_data: the data
// is stable and meaningful only while cnt_stop is high, and there is no
// back-pressure -- the scheduler must consume it inside the stop window.
// -----------------------------------------------------------------------------
interface counter_scheduler_if;
    import counter_sched_pkg::*;

    logic                                 cnt_start;
    logic                                 cnt_stop;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0]     cnt_data;

    modport master (
        output cnt_start,
        input  cnt_stop,
        input  cnt_data
    );

    modport slave (
        input  cnt_start,
        output cnt_stop,
        output cnt_data
    );

endinterface

// File: rtl/counter_sched_wdog.sv
// -----------------------------------------------------------------------------
// counter_sched_wdog
// Whole-second watchdog: a CLK_FREQ-cycle prescaler feeding a seconds counter.
// Ports:
//   clk     : system clock
//   res     : synchronous active-high reset
//   clear   : synchronous clear of prescaler and seconds (wins over enable)
//   enable  : count while high, hold while low
//   seconds : whole seconds elapsed while enabled; saturates at all-ones
// -----------------------------------------------------------------------------
module counter_sched_wdog
    import counter_sched_pkg::*;
#(
    parameter int CLK_FREQ = 200000000
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 clear,
    input  logic                 enable,
    output logic [SEC_WIDTH-1:0] seconds
);

    localparam int PRE_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ - 1);

    logic [PRE_W-1:0] prescale;

    always_ff @(posedge clk) begin
        if (res || clear) begin
            prescale <= '0;
            seconds  <= '0;
        end else if (enable) begin
            if (prescale == PRE_LAST) begin
                prescale <= '0;
                // Saturate so a stuck sequence cannot wrap back under the limit.
                if (seconds != '1) begin
                    seconds <= seconds + SEC_WIDTH'(1);
                end
            end else begin
                prescale <= prescale + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/counter_scheduler.sv
// -----------------------------------------------------------------------------
// counter_scheduler
// Sequences a number of runs of an external counter: strobes the counter,
// waits for its stop edge, accumulates the per-channel results, and repeats
// until the configured run count is reached. A whole-second watchdog aborts a
// run that never stops into the ERROR state.
// Optional build macro: COUNTER_SCHED_SAT_EN -- sums saturate instead of
// wrapping and a sat_flag output latches per-channel saturation.
// Ports:
//   clk, res            : clock, synchronous active-high reset
//   go                  : start pulse (honoured in IDLE/DONE/ERROR only)
//   abort               : level, ends an active sequence into IDLE
//   cfg_runs, cfg_time  : run count (0 means 1), per-run time in seconds
//   cnt (master)        : cnt_start / cnt_stop / cnt_data counter link
//   sum_data            : per-channel accumulated totals
//   run_idx             : completed runs in the current sequence
//   busy, done, timeout : status
//   sat_flag            : per-channel saturation (COUNTER_SCHED_SAT_EN only)
//   state_dbg           : current sequencer state
// -----------------------------------------------------------------------------
module counter_scheduler
    import counter_sched_pkg::*;
#(
    parameter int CLK_FREQ  = 200000000,
    parameter int SUM_WIDTH = 40
) (
    input  logic                              clk,
    input  logic                              res,
    input  logic                              go,
    input  logic                              abort,
    input  logic [7:0]                        cfg_runs,
    input  logic [7:0]                        cfg_time,
    counter_scheduler_if.master               cnt,
    output logic [NUM_CH-1:0][SUM_WIDTH-1:0]  sum_data,
    output logic [7:0]                        run_idx,
    output logic                              busy,
    output logic                              done,
    output logic                              timeout,
`ifdef COUNTER_SCHED_SAT_EN
    output logic [NUM_CH-1:0]                 sat_flag,
`endif
    output state_t                            state_dbg
);

    state_t                            state;
    logic [7:0]                        runs_q;
    logic [7:0]                        time_q;
    logic                              stop_q;
    logic                              stop_rise;
    logic                              wd_clear;
    logic                              wd_enable;
    logic                              wd_expired;
    logic [SEC_WIDTH-1:0]              seconds;
    logic [SEC_WIDTH-1:0]              wd_limit;
    logic [NUM_CH-1:0][SUM_WIDTH-1:0]  sum_next;
`ifdef COUNTER_SCHED_SAT_EN
    logic [SUM_WIDTH:0]                sum_wide;
    logic [NUM_CH-1:0]                 sat_hit;
`endif

    assign state_dbg = state;

    // Edge against the registered copy: a stop level that was already high
    // when WAIT_STOP was entered has stop_q high too, so it is not an edge.
    assign stop_rise = cnt.cnt_stop & ~stop_q;

    // Each run gets a fresh watchdog window; time spent in CAPTURE is a
    // single cycle and is not counted.
    assign wd_clear   = (state == ARM);
    assign wd_enable  = (state == WAIT_STOP) || (state == GAP);
    assign wd_limit   = SEC_WIDTH'(time_q) + SEC_WIDTH'(2);
    assign wd_expired = (seconds > wd_limit);

    counter_sched_wdog #(
        .CLK_FREQ (CLK_FREQ)
    ) u_wdog (
        .clk     (clk),
        .res     (res),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .seconds (seconds)
    );

    // Next accumulated value per channel; counter data is zero-extended.
    always_comb begin
        sum_next = '0;
`ifdef COUNTER_SCHED_SAT_EN
        sum_wide = '0;
        sat_hit  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_wide    = {1'b0, sum_data[i]} + (SUM_WIDTH + 1)'(cnt.cnt_data[i]);
            sat_hit[i]  = sum_wide[SUM_WIDTH];
            sum_next[i] = sat_hit[i] ? '1 : sum_wide[SUM_WIDTH-1:0];
        end
`else
        for (int i = 0; i < NUM_CH; i++) begin
            sum_next[i] = sum_data[i] + SUM_WIDTH'(cnt.cnt_data[i]);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state         <= IDLE;
            runs_q        <= '0;
            time_q        <= '0;
            stop_q        <= 1'b0;
            cnt.cnt_start <= 1'b0;
            sum_data      <= '0;
            run_idx       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
`ifdef COUNTER_SCHED_SAT_EN
            sat_flag      <= '0;
`endif
        end else begin
            stop_q        <= cnt.cnt_stop;
            cnt.cnt_start <= 1'b0;

            if (abort && state_is_busy(state)) begin
                // Abort keeps the partial results for inspection.
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE, ERROR: begin
                        // abort in the same cycle suppresses go.
                        if (go && !abort) begin
                            sum_data      <= '0;
                            run_idx       <= '0;
                            done          <= 1'b0;
                            timeout       <= 1'b0;
                            runs_q        <= (cfg_runs == 8'd0) ? 8'd1 : cfg_runs;
                            time_q        <= cfg_time;
`ifdef COUNTER_SCHED_SAT_EN
                            sat_flag      <= '0;
`endif
                            busy          <= 1'b1;
                            cnt.cnt_start <= 1'b1;
                            state         <= ARM;
                        end
                    end

                    ARM: begin
                        // cnt_start was raised on entry and drops here.
                        state <= WAIT_STOP;
                    end

                    WAIT_STOP: begin
                        if (stop_rise) begin
                            state <= CAPTURE;
                        end else if (wd_expired) begin
                            timeout <= 1'b1;
                            busy    <= 1'b0;
                            state   <= ERROR;
                        end
                    end

                    CAPTURE: begin
                        sum_data <= sum_next;
`ifdef COUNTER_SCHED_SAT_EN
                        sat_flag <= sat_flag | sat_hit;
`endif
                        run_idx  <= run_idx + 8'd1;
                        state    <= GAP;
                    end

                    GAP: begin
                        if (!cnt.cnt_stop) begin
                            if (run_idx == runs_q) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= DONE;
                            end else begin
                                cnt.cnt_start <= 1'b1;
                                state         <= ARM;
                            end
                        end else if (wd_expired) begin
                            timeout <= 1'b1;
                            busy    <= 1'b0;
                            state   <= ERROR;
                        end
                    end

                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_scheduler.sv
module tb_counter_scheduler;
    import counter_sched_pkg::*;

`ifdef COUNTER_SCHED_SAT_EN
    localparam int SW = 32;
`else
    localparam int SW = 33;
`endif
    localparam int EXP_W = NUM_CH * SW + 18;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    logic       go = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cfg_runs = 8'd0;
    logic [7:0] cfg_time = 8'd0;
    logic [NUM_CH-1:0][SW-1:0] sum_data;
    logic [7:0] run_idx;
    logic       busy;
    logic       done;
    logic       timeout;
    state_t     state_dbg;
`ifdef COUNTER_SCHED_SAT_EN
    logic [NUM_CH-1:0] sat_flag;
`endif

    counter_scheduler_if cif ();

    counter_scheduler #(
        .CLK_FREQ  (1000),
        .SUM_WIDTH (SW)
    ) dut (
        .clk       (clk),
        .res       (res),
        .go        (go),
        .abort     (abort),
        .cfg_runs  (cfg_runs),
        .cfg_time  (cfg_time),
        .cnt       (cif),
        .sum_data  (sum_data),
        .run_idx   (run_idx),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
`ifdef COUNTER_SCHED_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_exp;
    logic       busy_prev = 1'b0;
    logic [7:0] total_starts = 8'd0;
    logic [7:0] start_base = 8'd0;
    int         start_width = 0;
    logic       model_en = 1'b1;
    logic       model_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EXP_W-1:0] pack_exp(input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                                                  input logic [SW-1:0] s2, input logic [SW-1:0] s3,
                                                  input logic [7:0] run, input logic dn,
                                                  input logic to, input logic [7:0] st);
        return {s3, s2, s1, s0, run, dn, to, st};
    endfunction

    // ---------------- counter model ----------------
    initial begin
        cif.cnt_stop = 1'b0;
        cif.cnt_data = '0;
        forever begin
            @(negedge clk);
            if (cif.cnt_start && model_en) begin
                model_busy = 1'b1;
                repeat (1200) @(negedge clk);
                cif.cnt_stop = 1'b1;
                repeat (10) @(negedge clk);
                cif.cnt_stop = 1'b0;
                model_busy = 1'b0;
            end
        end
    end

    // ---------------- start strobe monitor ----------------
    always @(negedge clk) begin
        if (cif.cnt_start === 1'b1) begin
            total_starts = total_starts + 8'd1;
            start_width  = start_width + 1;
        end else if (start_width != 0) begin
            check("start_width", 64'(start_width), 64'd1);
            start_width = 0;
        end
    end

    // ---------------- end-of-sequence monitor ----------------
    always @(negedge clk) begin
        if (busy_prev === 1'b1 && busy === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL seq_end_unexpected: got busy fall expected none");
            end else begin
                mon_exp = exp_q.pop_front();
                for (int i = 0; i < NUM_CH; i++) begin
                    check($sformatf("sum_data[%0d]", i), 64'(sum_data[i]), 64'(mon_exp[18 + i*SW +: SW]));
                end
                check("run_idx", 64'(run_idx), 64'(mon_exp[17:10]));
                check("done", 64'(done), 64'(mon_exp[9]));
                check("timeout", 64'(timeout), 64'(mon_exp[8]));
                check("start_count", 64'(total_starts - start_base), 64'(mon_exp[7:0]));
            end
        end
        busy_prev = busy;
    end

    // ---------------- driver tasks ----------------
    task automatic start_seq(input logic [7:0] runs, input logic [7:0] tm);
        @(negedge clk);
        cfg_runs   = runs;
        cfg_time   = tm;
        start_base = total_starts;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_seq_end(input int bound);
        int k = 0;
        while (busy !== 1'b0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("seq_end_in_time", 64'(busy), 64'd0);
    endtask

    task automatic wait_model_idle();
        int k = 0;
        while (model_busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic set_data(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
        cif.cnt_data[0] = d0;
        cif.cnt_data[1] = d1;
        cif.cnt_data[2] = d2;
        cif.cnt_data[3] = d3;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        check("rst_outs", 64'({cif.cnt_start, busy, done, timeout, run_idx}), 64'd0);
        check("rst_sums", 64'(sum_data), 64'd0);
        res = 1'b0;
        repeat (2) @(negedge clk);

        // three runs of {5,6,7,8}
        set_data(32'd5, 32'd6, 32'd7, 32'd8);
        exp_q.push_back(pack_exp(SW'(15), SW'(18), SW'(21), SW'(24), 8'd3, 1'b1, 1'b0, 8'd3));
        start_seq(8'd3, 8'd2);
        wait_seq_end(6000);
        check("done_state", 64'(state_dbg), 64'(DONE));
        wait_model_idle();
        check("done_hold", 64'({done, busy, run_idx}), 64'({1'b1, 1'b0, 8'd3}));

        // cfg_runs = 0 behaves as a single run
        exp_q.push_back(pack_exp(SW'(5), SW'(6), SW'(7), SW'(8), 8'd1, 1'b1, 1'b0, 8'd1));
        start_seq(8'd0, 8'd2);
        wait_seq_end(3000);
        wait_model_idle();

        // counter never stops: watchdog fires after more than cfg_time+2 s
        model_en = 1'b0;
        exp_q.push_back(pack_exp(SW'(0), SW'(0), SW'(0), SW'(0), 8'd0, 1'b0, 1'b1, 8'd1));
        start_seq(8'd2, 8'd1);
        wait_seq_end(6000);
        repeat (300) @(negedge clk);
        check("error_state", 64'(state_dbg), 64'(ERROR));
        check("error_no_restrobe", 64'(total_starts - start_base), 64'd1);
        model_en = 1'b1;

        // go from ERROR restarts with cleared sums and timeout
        set_data(32'd1, 32'd2, 32'd3, 32'd4);
        exp_q.push_back(pack_exp(SW'(1), SW'(2), SW'(3), SW'(4), 8'd1, 1'b1, 1'b0, 8'd1));
        start_seq(8'd1, 8'd2);
        wait_seq_end(3000);
        wait_model_idle();

        // abort during run 2 of 4, go asserted together with abort
        set_data(32'd5, 32'd6, 32'd7, 32'd8);
        exp_q.push_back(pack_exp(SW'(5), SW'(6), SW'(7), SW'(8), 8'd1, 1'b0, 1'b0, 8'd2));
        start_seq(8'd4, 8'd2);
        k = 0;
        while ((total_starts - start_base) != 8'd2 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("second_start_seen", 64'(total_starts - start_base), 64'd2);
        repeat (100) @(negedge clk);
        abort = 1'b1;
        go    = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        go    = 1'b0;
        check("abort_state", 64'(state_dbg), 64'(IDLE));
        check("abort_flags", 64'({busy, done}), 64'd0);
        check("abort_run_idx", 64'(run_idx), 64'd1);
        wait_model_idle();

        // sum width boundary: two runs of all-ones on channel 0
        set_data(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
`ifdef COUNTER_SCHED_SAT_EN
        exp_q.push_back(pack_exp(SW'(32'hFFFF_FFFF), SW'(0), SW'(0), SW'(0), 8'd2, 1'b1, 1'b0, 8'd2));
`else
        exp_q.push_back(pack_exp(SW'(33'h1_FFFF_FFFE), SW'(0), SW'(0), SW'(0), 8'd2, 1'b1, 1'b0, 8'd2));
`endif
        start_seq(8'd2, 8'd2);
        wait_seq_end(6000);
`ifdef COUNTER_SCHED_SAT_EN
        check("sat_flag", 64'(sat_flag), 64'h1);
`endif
        wait_model_idle();

        // reset while waiting for stop: everything clears, late stop ignored
        set_data(32'd9, 32'd9, 32'd9, 32'd9);
        exp_q.push_back(pack_exp(SW'(0), SW'(0), SW'(0), SW'(0), 8'd0, 1'b0, 1'b0, 8'd1));
        start_seq(8'd2, 8'd2);
        k = 0;
        while (state_dbg != WAIT_STOP && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (50) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        check("res_state", 64'(state_dbg), 64'(IDLE));
        check("res_outs", 64'({cif.cnt_start, busy, done, timeout, run_idx}), 64'd0);
        check("res_sums", 64'(sum_data), 64'd0);
        res = 1'b0;
        wait_model_idle();
        repeat (10) @(negedge clk);
        check("late_stop_state", 64'(state_dbg), 64'(IDLE));
        check("late_stop_sums", 64'(sum_data), 64'd0);
        check("late_stop_run_idx", 64'(run_idx), 64'd0);
        check("late_stop_no_strobe", 64'(total_starts - start_base), 64'd1);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
